fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequencing controller for the five-stage pipeline's instruction fetch unit. Each cycle it decides whether the PC advances, holds, or is redirected (branch, jump, jump-register), and whether the IF/ID and ID/EX pipeline registers are written or flushed. It arbitrates between simultaneous redirect and stall requests from the ID and EX stages. It also counts stall and flush cycles for performance checking.

## Interface
Parameters:
- BOOT_CYCLES, 2: cycles after reset release during which the PC is held and IF/ID is flushed (instruction memory settle time); legal range 1..15.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- branch_ex  in  1  branch instruction in EX.
- zero_ex  in  1  ALU zero flag in EX; a branch is taken when branch_ex=1 and zero_ex=0.
- jump_id  in  1  jump (j/jal) decoded in ID.
- jumpR_id  in  1  jump-register decoded in ID.
- memRead_ex  in  1  load in EX.
- rt_ex  in  5  destination register of the load in EX.
- rs_id, rt_id  in  5 each  source registers of the instruction in ID.
- pc_sel  out  2  PC source: 0 sequential, 1 branch target, 2 jump target, 3 register (Da).
- pc_write  out  1  PC register enable.
- add_one_enable  out  1  enables the PC incrementer.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  loads a bubble (all-zero instruction) into IF/ID.
- idex_flush  out  1  loads a bubble (all control signals 0) into ID/EX.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.
- flush_count  out  CNT_W  saturating count of redirect cycles.

## Operation
- The state register is 2 bits: BOOT, RUN, STALL, FLUSH. All outputs except the counters are combinational from the state and the current inputs (Mealy). The counters are registered.
- Request terms:
  - br_taken = branch_ex & ~zero_ex.
  - lu_hazard = memRead_ex & (rt_ex != 0) & (rt_ex == rs_id | rt_ex == rt_id).
  - jr = jumpR_id.
  - j = jump_id & ~jumpR_id.
- Priority in RUN and STALL: br_taken > lu_hazard > jr > j > sequential.
- BOOT:
  - Outputs: pc_write=0, add_one_enable=0, ifid_flush=1, idex_flush=1, pc_sel=0.
  - A 4-bit boot counter is loaded with BOOT_CYCLES-1 at reset and decrements each cycle.
  - At count 0 the state moves to RUN.
- RUN / STALL actions, applied in priority order:
  - br_taken: pc_sel=1, pc_write=1, add_one_enable=1, ifid_flush=1, idex_flush=1; next state FLUSH; flush_count+1.
  - lu_hazard: pc_write=0, ifid_write=0, idex_flush=1, add_one_enable=0; next state STALL; stall_count+1.
  - jr: pc_sel=3, pc_write=1, ifid_flush=1; next state FLUSH; flush_count+1.
  - j: pc_sel=2, pc_write=1, ifid_flush=1; next state FLUSH; flush_count+1.
  - None of the above: pc_sel=0, pc_write=1, add_one_enable=1, ifid_write=1; next state RUN.
- FLUSH lasts one cycle. The ID stage holds a bubble, so jump_id, jumpR_id and lu_hazard are ignored. br_taken is still honoured, which allows back-to-back branches. Otherwise the cycle advances sequentially and the next state is RUN.
- STALL repeats for as long as lu_hazard holds. In the codebase hazard logic it clears after 1 cycle, because the load moves to MEM.
- Counters saturate at all-ones and do not wrap.
- Any output that no action above sets is 0, except ifid_write, which is 1 unless the action sets it to 0.

## Timing
- Reset asserted (reset=0), immediately and asynchronously:
  - state=BOOT, boot counter=BOOT_CYCLES-1, stall_count=0, flush_count=0.
  - Outputs take their BOOT values: pc_write=0, ifid_flush=1, idex_flush=1, pc_sel=0, add_one_enable=0, ifid_write=1.
- The first sequential PC write occurs on the rising edge BOOT_CYCLES+1 after reset release. The first BOOT_CYCLES edges are hold cycles.
- Redirect latency: the target is loaded on the same edge that the request is sampled. Cost is 1 bubble for j/jr and 2 bubbles for a branch.
- Simultaneous br_taken with lu_hazard or a jump: the branch wins and the younger instructions are flushed.
- Reset asserted in the middle of STALL or FLUSH returns the block to BOOT. Counters clear and no partial redirect is retained.
- The outputs are combinational paths. The input-to-output path must close within one cycle together with the PC mux.

## Test plan
- Reset release with BOOT_CYCLES=2 and no requests -> pc_write=0 for 2 cycles, then 1 every cycle with pc_sel=0. stall_count=0 and flush_count=0 throughout.
- Load-use: memRead_ex=1, rt_ex=8, rs_id=8 for 1 cycle -> pc_write=0, ifid_write=0, idex_flush=1 for exactly 1 cycle. stall_count=1, state returns to RUN.
- rt_ex=0 with rs_id=0 and memRead_ex=1 -> no stall; stall_count stays 0.
- jumpR_id=1 and jump_id=1 together -> pc_sel=3, ifid_flush=1. On the next cycle, jump_id=1 is ignored (FLUSH) and pc_sel=0. flush_count=1.
- branch_ex=1, zero_ex=0, simultaneous with lu_hazard and jump_id -> pc_sel=1, ifid_flush=1, idex_flush=1, stall_count unchanged. With zero_ex=1 instead, the branch is not taken: the stall occurs and pc_sel≠1.
- Counter saturation, with CNT_W=4: 20 redirects -> flush_count=15. Reset asserted mid-STALL -> outputs take BOOT values with no clock edge, and both counters read 0.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencing controller: PC advance/hold/redirect, IF/ID and
// ID/EX write/flush control, and saturating stall/flush performance counters.
module fetch_controller #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_ex,
  input  logic             zero_ex,
  input  logic             jump_id,
  input  logic             jumpR_id,
  input  logic             memRead_ex,
  input  logic [4:0]       rt_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  output logic [1:0]       pc_sel,
  output logic             pc_write,
  output logic             add_one_enable,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       boot_cnt_q, boot_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic br_taken, lu_hazard, jr_req, j_req, in_flush;
  logic stall_inc, flush_inc;

  assign br_taken  = branch_ex & ~zero_ex;
  assign lu_hazard = memRead_ex & (rt_ex != '0) & ((rt_ex == rs_id) | (rt_ex == rt_id));
  assign jr_req    = jumpR_id;
  assign j_req     = jump_id & ~jumpR_id;

  always_comb begin
    state_d        = state_q;
    boot_cnt_d     = boot_cnt_q;
    pc_sel         = 2'd0;
    pc_write       = 1'b0;
    add_one_enable = 1'b0;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    // FLUSH holds a bubble in ID, so only the EX-stage branch request is live.
    in_flush       = (state_q == S_FLUSH);

    if (state_q == S_BOOT) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (boot_cnt_q == '0) begin
        state_d = S_RUN;
      end else begin
        boot_cnt_d = boot_cnt_q - 4'd1;
      end
    end else if (br_taken) begin
      pc_sel         = 2'd1;
      pc_write       = 1'b1;
      add_one_enable = 1'b1;
      ifid_flush     = 1'b1;
      idex_flush     = 1'b1;
      flush_inc      = 1'b1;
      state_d        = S_FLUSH;
    end else if (lu_hazard && !in_flush) begin
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
      state_d    = S_STALL;
    end else if (jr_req && !in_flush) begin
      pc_sel     = 2'd3;
      pc_write   = 1'b1;
      ifid_flush = 1'b1;
      flush_inc  = 1'b1;
      state_d    = S_FLUSH;
    end else if (j_req && !in_flush) begin
      pc_sel     = 2'd2;
      pc_write   = 1'b1;
      ifid_flush = 1'b1;
      flush_inc  = 1'b1;
      state_d    = S_FLUSH;
    end else begin
      pc_write       = 1'b1;
      add_one_enable = 1'b1;
      state_d        = S_RUN;
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= BOOT_INIT;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: each cycle pushes the expected output
// vector when stimulus is driven and pops/compares it once the outputs settle.
module tb_fetch_controller;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             branch_ex = 1'b0, zero_ex = 1'b0, jump_id = 1'b0, jumpR_id = 1'b0;
  logic             memRead_ex = 1'b0;
  logic [4:0]       rt_ex = '0, rs_id = '0, rt_id = '0;
  logic [1:0]       pc_sel;
  logic             pc_write, add_one_enable, ifid_write, ifid_flush, idex_flush;
  logic [CNT_W-1:0] stall_count, flush_count;

  fetch_controller #(.BOOT_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .branch_ex(branch_ex), .zero_ex(zero_ex), .jump_id(jump_id), .jumpR_id(jumpR_id),
    .memRead_ex(memRead_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .pc_sel(pc_sel), .pc_write(pc_write), .add_one_enable(add_one_enable),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // {pc_sel, pc_write, add_one_enable, ifid_write, ifid_flush, idex_flush, stall, flush}
  typedef logic [14:0] obs_t;
  typedef struct packed {
    logic br, z, j, jr, mr;
    logic [4:0] rte, rs, rt;
  } stim_t;
  typedef enum int {A_BOOT, A_SEQ, A_BR, A_LU, A_JR, A_J} act_e;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sc = 0, fc = 0;
  obs_t got, ex;

  function automatic stim_t mk(int br, int z, int j, int jr, int mr, int rte, int rs, int rt);
    stim_t s;
    s.br = br[0]; s.z = z[0]; s.j = j[0]; s.jr = jr[0]; s.mr = mr[0];
    s.rte = 5'(rte); s.rs = 5'(rs); s.rt = 5'(rt);
    return s;
  endfunction

  function automatic obs_t exp_of(act_e a, int s, int f);
    logic [1:0] sel;
    logic [4:0] c;
    case (a)
      A_BOOT:  begin sel = 2'd0; c = 5'b00111; end
      A_SEQ:   begin sel = 2'd0; c = 5'b11100; end
      A_BR:    begin sel = 2'd1; c = 5'b11111; end
      A_LU:    begin sel = 2'd0; c = 5'b00001; end
      A_JR:    begin sel = 2'd3; c = 5'b10110; end
      default: begin sel = 2'd2; c = 5'b10110; end
    endcase
    return {sel, c, 4'(s), 4'(f)};
  endfunction

  task automatic push_exp(act_e a);
    sb.push_back(exp_of(a, sc, fc));
    if (a == A_LU && sc < 15) sc++;
    if ((a == A_BR || a == A_JR || a == A_J) && fc < 15) fc++;
  endtask

  task automatic drive(stim_t s);
    @(negedge clk);
    branch_ex = s.br; zero_ex = s.z; jump_id = s.j; jumpR_id = s.jr;
    memRead_ex = s.mr; rt_ex = s.rte; rs_id = s.rs; rt_id = s.rt;
  endtask

  function automatic obs_t sample();
    return {pc_sel, pc_write, add_one_enable, ifid_write, ifid_flush, idex_flush,
            stall_count, flush_count};
  endfunction

  task automatic test_reset();
    act_e ac[5] = '{A_BOOT, A_BOOT, A_SEQ, A_SEQ, A_SEQ};
    reset = 1'b1;
    #1 reset = 1'b0;
    sc = 0; fc = 0;
    push_exp(A_BOOT);
    #1 got = sample(); ex = sb.pop_front(); n_checks++;
    if (got !== ex) begin n_fail++; $display("FAIL reset_async: got %h expected %h", got, ex); end
    repeat (2) @(posedge clk);
    push_exp(A_BOOT);
    #1 got = sample(); ex = sb.pop_front(); n_checks++;
    if (got !== ex) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", got, ex); end
    for (int i = 0; i < 5; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
      if (i == 0) reset = 1'b1;
      push_exp(ac[i]);
      #1 got = sample(); ex = sb.pop_front(); n_checks++;
      if (got !== ex) begin n_fail++; $display("FAIL boot_release[%0d]: got %h expected %h", i, got, ex); end
    end
  endtask

  task automatic test_load_use();
    stim_t st[6];
    act_e  ac[6];
    st[0] = mk(0, 0, 0, 0, 1, 8, 8, 3);  ac[0] = A_LU;
    st[1] = mk(0, 0, 0, 0, 0, 0, 0, 0);  ac[1] = A_SEQ;
    st[2] = mk(0, 0, 0, 0, 0, 0, 0, 0);  ac[2] = A_SEQ;
    st[3] = mk(0, 0, 0, 0, 1, 9, 2, 9);  ac[3] = A_LU;
    st[4] = mk(0, 0, 0, 0, 0, 9, 2, 9);  ac[4] = A_SEQ;
    st[5] = mk(0, 0, 0, 0, 1, 9, 8, 7);  ac[5] = A_SEQ;
    for (int i = 0; i < 6; i++) begin
      drive(st[i]); push_exp(ac[i]);
      #1 got = sample(); ex = sb.pop_front(); n_checks++;
      if (got !== ex) begin n_fail++; $display("FAIL load_use[%0d]: got %h expected %h", i, got, ex); end
    end
  endtask

  task automatic test_r0_no_stall();
    stim_t st[2];
    st[0] = mk(0, 0, 0, 0, 1, 0, 0, 0);
    st[1] = mk(0, 0, 0, 0, 1, 0, 0, 5);
    for (int i = 0; i < 2; i++) begin
      drive(st[i]); push_exp(A_SEQ);
      #1 got = sample(); ex = sb.pop_front(); n_checks++;
      if (got !== ex) begin n_fail++; $display("FAIL r0_no_stall[%0d]: got %h expected %h", i, got, ex); end
    end
  endtask

  task automatic test_jump();
    stim_t st[8];
    act_e  ac[8];
    st[0] = mk(0, 0, 1, 1, 0, 0, 0, 0);  ac[0] = A_JR;
    st[1] = mk(0, 0, 1, 0, 0, 0, 0, 0);  ac[1] = A_SEQ;
    st[2] = mk(0, 0, 0, 0, 0, 0, 0, 0);  ac[2] = A_SEQ;
    st[3] = mk(0, 0, 1, 0, 0, 0, 0, 0);  ac[3] = A_J;
    st[4] = mk(0, 0, 0, 1, 1, 4, 4, 0);  ac[4] = A_SEQ;
    st[5] = mk(0, 0, 0, 1, 0, 0, 0, 0);  ac[5] = A_JR;
    st[6] = mk(0, 0, 0, 0, 0, 0, 0, 0);  ac[6] = A_SEQ;
    st[7] = mk(0, 0, 0, 0, 0, 0, 0, 0);  ac[7] = A_SEQ;
    for (int i = 0; i < 8; i++) begin
      drive(st[i]); push_exp(ac[i]);
      #1 got = sample(); ex = sb.pop_front(); n_checks++;
      if (got !== ex) begin n_fail++; $display("FAIL jump[%0d]: got %h expected %h", i, got, ex); end
    end
  endtask

  task automatic test_branch_priority();
    stim_t st[10];
    act_e  ac[10];
    st[0] = mk(1, 0, 1, 0, 1, 5, 5, 0);  ac[0] = A_BR;
    st[1] = mk(0, 0, 0, 0, 0, 0, 0, 0);  ac[1] = A_SEQ;
    st[2] = mk(1, 0, 0, 0, 0, 0, 0, 0);  ac[2] = A_BR;
    st[3] = mk(1, 0, 0, 0, 0, 0, 0, 0);  ac[3] = A_BR;
    st[4] = mk(0, 0, 0, 0, 0, 0, 0, 0);  ac[4] = A_SEQ;
    st[5] = mk(1, 1, 1, 0, 1, 5, 5, 0);  ac[5] = A_LU;
    st[6] = mk(0, 0, 0, 0, 0, 0, 0, 0);  ac[6] = A_SEQ;
    st[7] = mk(0, 0, 0, 0, 1, 6, 0, 6);  ac[7] = A_LU;
    st[8] = mk(1, 0, 0, 1, 1, 6, 0, 6);  ac[8] = A_BR;
    st[9] = mk(0, 0, 0, 0, 0, 0, 0, 0);  ac[9] = A_SEQ;
    for (int i = 0; i < 10; i++) begin
      drive(st[i]); push_exp(ac[i]);
      #1 got = sample(); ex = sb.pop_front(); n_checks++;
      if (got !== ex) begin n_fail++; $display("FAIL branch[%0d]: got %h expected %h", i, got, ex); end
    end
  endtask

  task automatic test_stall_repeat();
    stim_t st[3];
    act_e  ac[3];
    st[0] = mk(0, 0, 0, 0, 1, 12, 12, 0);  ac[0] = A_LU;
    st[1] = mk(0, 0, 1, 0, 1, 12, 0, 12);  ac[1] = A_LU;
    st[2] = mk(0, 0, 0, 0, 0, 0, 0, 0);    ac[2] = A_SEQ;
    for (int i = 0; i < 3; i++) begin
      drive(st[i]); push_exp(ac[i]);
      #1 got = sample(); ex = sb.pop_front(); n_checks++;
      if (got !== ex) begin n_fail++; $display("FAIL stall_repeat[%0d]: got %h expected %h", i, got, ex); end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 42; i++) begin
      if (i < 20)       begin drive(mk(1, 0, 0, 0, 0, 0, 0, 0));   push_exp(A_BR);  end
      else if (i == 20) begin drive(mk(0, 0, 0, 0, 0, 0, 0, 0));   push_exp(A_SEQ); end
      else if (i < 41)  begin drive(mk(0, 0, 0, 0, 1, 7, 7, 0));   push_exp(A_LU);  end
      else              begin drive(mk(0, 0, 0, 0, 0, 0, 0, 0));   push_exp(A_SEQ); end
      #1 got = sample(); ex = sb.pop_front(); n_checks++;
      if (got !== ex) begin n_fail++; $display("FAIL saturation[%0d]: got %h expected %h", i, got, ex); end
    end
  endtask

  task automatic test_reset_mid_stall();
    for (int i = 0; i < 2; i++) begin
      drive(mk(0, 0, 0, 0, 1, 10, 10, 0)); push_exp(A_LU);
      #1 got = sample(); ex = sb.pop_front(); n_checks++;
      if (got !== ex) begin n_fail++; $display("FAIL mid_stall_pre[%0d]: got %h expected %h", i, got, ex); end
    end
    test_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_r0_no_stall();
    test_jump();
    test_branch_priority();
    test_stall_repeat();
    test_saturation();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
